// File: rtl/adc_spi_reader.sv
// adc_spi_reader
//   Reads 24-bit conversions from a SPI ADC each time its DRDY line goes low.
//   It averages 2^AVG_LOG2 consecutive samples and presents the truncated
//   mean on adc_value, with a one-cycle adc_valid strobe.
//
// Parameters
//   SCLK_DIV : system-clock cycles per SCLK half-period
//   AVG_LOG2 : log2 of the number of samples averaged per output
//   TIMEOUT  : cycles to wait for DRDY before flagging adc_timeout
//
// Ports
//   CLK100MHZ   in   system clock (rising edge)
//   rst         in   asynchronous active-high reset
//   adc_drdy_n  in   ADC data ready, active low, asynchronous
//   adc_miso    in   ADC serial data, MSB first, asynchronous
//   adc_sclk    out  SPI clock, idles low
//   adc_cs_n    out  ADC chip select, active low
//   adc_value   out  averaged unsigned result, held between updates
//   adc_valid   out  one-cycle pulse when adc_value updates
//   adc_timeout out  sticky DRDY-timeout flag, cleared by the next average
module adc_spi_reader #(
  parameter int SCLK_DIV = 50,
  parameter int AVG_LOG2 = 3,
  parameter int TIMEOUT  = 10000000
) (
  input  logic        CLK100MHZ,
  input  logic        rst,
  input  logic        adc_drdy_n,
  input  logic        adc_miso,
  output logic        adc_sclk,
  output logic        adc_cs_n,
  output logic [23:0] adc_value,
  output logic        adc_valid,
  output logic        adc_timeout
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int ACC_W = 24 + AVG_LOG2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DRDY,
    CS_SETUP,
    SHIFT,
    DONE,
    REARM
  } state_t;

  state_t state_q, state_d;

  // Two-flop synchronizers. The DRDY chain resets to its inactive (high)
  // level so that the first WAIT_DRDY cycle after reset cannot see a
  // phantom data-ready before the real input has propagated through.
  logic [1:0] drdy_sync_q;
  logic [1:0] miso_sync_q;
  logic       drdy_s;
  logic       miso_s;

  logic [DIV_W-1:0]    div_q, div_d;
  logic                phase_q, phase_d;   // 0: SCLK low half, 1: high half
  logic [4:0]          bit_q, bit_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [23:0]         shift_q, shift_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    acc_sum;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic [23:0]         value_q, value_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;

  assign drdy_s = drdy_sync_q[1];
  assign miso_s = miso_sync_q[1];

  // Sum is wide enough for 2^AVG_LOG2 full-scale samples, so it never wraps.
  assign acc_sum = acc_q + ACC_W'(shift_q);

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      drdy_sync_q <= 2'b11;
      miso_sync_q <= 2'b00;
      state_q     <= IDLE;
      div_q       <= '0;
      phase_q     <= 1'b0;
      bit_q       <= '0;
      tmo_q       <= '0;
      shift_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
    end else begin
      drdy_sync_q <= {drdy_sync_q[0], adc_drdy_n};
      miso_sync_q <= {miso_sync_q[0], adc_miso};
      state_q     <= state_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      tmo_q       <= tmo_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    tmo_d     = tmo_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    value_d   = value_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        state_d = WAIT_DRDY;
      end

      WAIT_DRDY: begin
        if (!drdy_s) begin
          state_d = CS_SETUP;
          tmo_d   = '0;
          div_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          // Keep waiting; the partial average is deliberately retained.
          timeout_d = 1'b1;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      CS_SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            // Last cycle of the high half: data has been stable for a
            // full period, well past the synchronizer latency.
            shift_d = {shift_q[22:0], miso_s};
            phase_d = 1'b0;
            if (bit_q == 5'd23) begin
              state_d = DONE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      DONE: begin
        state_d = REARM;
        if (cnt_q == '1) begin
          value_d   = acc_sum[AVG_LOG2 +: 24];
          valid_d   = 1'b1;
          acc_d     = '0;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
        end
      end

      REARM: begin
        // One DRDY assertion yields one read: wait for it to go away.
        if (drdy_s) begin
          state_d = WAIT_DRDY;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // SPI pins are registered from the next state so they switch cleanly
    // with the state they belong to.
    sclk_d = (state_d == SHIFT) && phase_d;
    cs_n_d = !((state_d == CS_SETUP) || (state_d == SHIFT));
  end

  assign adc_sclk    = sclk_q;
  assign adc_cs_n    = cs_n_q;
  assign adc_value   = value_q;
  assign adc_valid   = valid_q;
  assign adc_timeout = timeout_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Testbench for adc_spi_reader: a bus-level ADC model shifts out a word per
// DRDY assertion; expected averages go into a queue and a negedge monitor
// pops and compares them whenever adc_valid is seen.
module tb_adc_spi_reader;

  localparam int SCLK_DIV = 4;
  localparam int AVG_LOG2 = 3;
  localparam int TIMEOUT  = 3000;
  localparam int FRAME    = 49 * SCLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adc_drdy_n = 1'b1;
  logic        adc_miso;
  logic        adc_sclk;
  logic        adc_cs_n;
  logic [23:0] adc_value;
  logic        adc_valid;
  logic        adc_timeout;

  int tests = 0;
  int fails = 0;

  logic [23:0] exp_q[$];
  logic [23:0] cur_word = 24'd0;
  int          fall_cnt = 0;

  int          n_valid = 0;
  int          cs_falls = 0;
  int          cs_low_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [23:0] prev_value = 24'd0;
  logic        prev_cs = 1'b1;

  adc_spi_reader #(
    .SCLK_DIV(SCLK_DIV),
    .AVG_LOG2(AVG_LOG2),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK100MHZ  (clk),
    .rst        (rst),
    .adc_drdy_n (adc_drdy_n),
    .adc_miso   (adc_miso),
    .adc_sclk   (adc_sclk),
    .adc_cs_n   (adc_cs_n),
    .adc_value  (adc_value),
    .adc_valid  (adc_valid),
    .adc_timeout(adc_timeout)
  );

  always #5 clk = ~clk;

  // ADC model: MSB presented at CS fall, next bit after each SCLK fall.
  always @(negedge adc_sclk or posedge adc_cs_n) begin
    if (adc_cs_n) fall_cnt <= 0;
    else          fall_cnt <= fall_cnt + 1;
  end
  assign adc_miso = (fall_cnt < 24) ? cur_word[23 - fall_cnt] : 1'b0;

  function automatic void check(input string name, input longint unsigned act,
                                input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %0d", name, act);
    end
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_value <= 24'd0;
      cs_low_cnt <= 0;
      prev_cs    <= 1'b1;
    end else begin
      if (adc_valid) begin
        n_valid <= n_valid + 1;
        check("valid_not_back_to_back", prev_valid, 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_valid: got value %0d, expected no pulse", adc_value);
        end else begin
          check("avg_value", adc_value, exp_q.pop_front());
        end
      end
      if (adc_value != prev_value) check("value_changes_only_with_valid", adc_valid, 1);
      prev_valid <= adc_valid;
      prev_value <= adc_value;
      if (prev_cs && !adc_cs_n) cs_falls <= cs_falls + 1;
      prev_cs <= adc_cs_n;
      if (!adc_cs_n) begin
        cs_low_cnt <= cs_low_cnt + 1;
      end else if (cs_low_cnt != 0) begin
        check("cs_low_cycles", cs_low_cnt, FRAME);
        cs_low_cnt <= 0;
      end
    end
  end

  task automatic wait_cs(input logic level, input string name);
    int n = 0;
    while (adc_cs_n !== level && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (adc_cs_n !== level) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: cs_n stuck at %b, expected %b", name, adc_cs_n, level);
    end
  endtask

  task automatic do_sample(input logic [23:0] v);
    cur_word   = v;
    adc_drdy_n = 1'b0;
    wait_cs(1'b0, "wait_cs_fall");
    adc_drdy_n = 1'b1;
    wait_cs(1'b1, "wait_cs_rise");
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int v0;
    int n;
    int r;
    logic ps;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_value", adc_value, 0);
    check("rst_valid", adc_valid, 0);
    check("rst_timeout", adc_timeout, 0);
    check("rst_sclk", adc_sclk, 0);
    check("rst_cs_n", adc_cs_n, 1);
    @(posedge clk); #2 rst = 1'b0;
    repeat (4) @(negedge clk);

    // Mid-scale x8
    v0 = n_valid;
    exp_q.push_back(24'h800000);
    repeat (8) do_sample(24'h800000);
    check("mid_scale_pulses", n_valid - v0, 1);

    // Full-scale x8: accumulator must not wrap
    v0 = n_valid;
    exp_q.push_back(24'hFFFFFF);
    repeat (8) do_sample(24'hFFFFFF);
    check("full_scale_pulses", n_valid - v0, 1);

    // 3000000..3000007 -> truncated mean 3000003
    v0 = n_valid;
    exp_q.push_back(24'd3000003);
    for (int i = 0; i < 8; i++) do_sample(24'(3000000 + i));
    check("ramp_pulses", n_valid - v0, 1);

    // Timeout with a partial average in flight: 3x100 + 5x200 -> 1300/8 = 162
    v0 = n_valid;
    exp_q.push_back(24'd162);
    repeat (3) do_sample(24'd100);
    check("timeout_clear_before", adc_timeout, 0);
    n = 0;
    while (!adc_timeout && n < 2 * TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n < TIMEOUT - 5 || n > TIMEOUT + 1) begin
      fails++;
      $display("[TB] FAIL timeout_latency: got %0d cycles, expected about %0d", n, TIMEOUT - 3);
    end
    repeat (50) @(negedge clk);
    check("timeout_sticky", adc_timeout, 1);
    do_sample(24'd200);
    check("timeout_kept_by_sample", adc_timeout, 1);
    repeat (4) do_sample(24'd200);
    check("timeout_cleared_by_avg", adc_timeout, 0);
    check("partial_avg_pulses", n_valid - v0, 1);

    // Reset during bit 12 of sample 5
    repeat (4) do_sample(24'h111111);
    cur_word   = 24'h222222;
    adc_drdy_n = 1'b0;
    wait_cs(1'b0, "wait_cs_fall");
    adc_drdy_n = 1'b1;
    r = 0; n = 0; ps = adc_sclk;
    while (r < 12 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
      if (adc_sclk && !ps) r++;
      ps = adc_sclk;
    end
    check("reached_bit12", r, 12);
    #2 rst = 1'b1;
    #1;
    check("midframe_rst_cs_n", adc_cs_n, 1);
    check("midframe_rst_sclk", adc_sclk, 0);
    check("midframe_rst_value", adc_value, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    v0 = n_valid;
    exp_q.push_back(24'd45);
    for (int i = 1; i <= 8; i++) do_sample(24'(10 * i));
    check("post_rst_pulses", n_valid - v0, 1);

    // DRDY held low for ten frames: one read only
    v0 = n_valid;
    exp_q.push_back(24'd100);
    r = cs_falls;
    cur_word   = 24'd800;
    adc_drdy_n = 1'b0;
    repeat (10 * (FRAME + 10)) @(negedge clk);
    check("held_drdy_frames", cs_falls - r, 1);
    check("held_drdy_cs_idle", adc_cs_n, 1);
    adc_drdy_n = 1'b1;
    repeat (6) @(negedge clk);
    repeat (7) do_sample(24'd0);
    check("held_drdy_pulses", n_valid - v0, 1);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
